// File: rtl/nmos_phase_gen_if.sv
// nmos_phase_gen_if: run/step/halted handshake and phase enables
// for the NMOS two-phase clock-enable generator.
interface nmos_phase_gen_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             step;
  logic             halted;
  logic             phi1;
  logic             phi2;
  logic             ld;
  logic             phi1_rise;
  logic [CNT_W-1:0] cyc_cnt;

  modport master (
    output run,
    output step,
    input  halted,
    input  phi1,
    input  phi2,
    input  ld,
    input  phi1_rise,
    input  cyc_cnt
  );

  modport slave (
    input  run,
    input  step,
    output halted,
    output phi1,
    output phi2,
    output ld,
    output phi1_rise,
    output cyc_cnt
  );
endinterface

// File: rtl/nmos_phase_gen.sv
// nmos_phase_gen: two-phase non-overlapping clock-enable generator
// with free-run / single-step / halt control and cycle counter.
module nmos_phase_gen #(
  parameter int PHI1_W = 3,
  parameter int PHI2_W = 3,
  parameter int GAP_W  = 1,
  parameter int CNT_W  = 16
) (
  input  logic main_clk,
  input  logic rst_n,
  nmos_phase_gen_if.slave bus
);

  localparam int MW12 = (PHI1_W > PHI2_W) ? PHI1_W : PHI2_W;
  localparam int MAXW = (MW12 > GAP_W) ? MW12 : GAP_W;
  localparam int CW   = $clog2(MAXW + 1);

  localparam logic [CW-1:0] P1L = CW'(PHI1_W - 1);
  localparam logic [CW-1:0] P2L = CW'(PHI2_W - 1);
  localparam logic [CW-1:0] GL  =
    CW'((GAP_W > 0) ? GAP_W - 1 : 0);

  if (PHI1_W < 1 || PHI2_W < 1) begin : g_bad_param
    $error("nmos_phase_gen: PHI1_W and PHI2_W must be >= 1");
  end

  typedef enum logic [2:0] {
    HALT, PH1, GAP12, PH2, GAP21
  } state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [CW-1:0]    r_pcnt;
  logic [CW-1:0]    w_pcnt;
  logic             w_bnd;

  logic             r_halted;
  logic             r_phi1;
  logic             r_phi2;
  logic             r_ld;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  logic             w_halted;
  logic             w_phi1;
  logic             w_phi2;
  logic             w_ld;
  logic             w_rise;
  logic [CNT_W-1:0] w_cnt;

  // State, phase counter and registered outputs.
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= HALT;
      r_pcnt   <= '0;
      r_halted <= 1'b1;
      r_phi1   <= 1'b0;
      r_phi2   <= 1'b0;
      r_ld     <= 1'b0;
      r_rise   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_nxt;
      r_pcnt   <= w_pcnt;
      r_halted <= w_halted;
      r_phi1   <= w_phi1;
      r_phi2   <= w_phi2;
      r_ld     <= w_ld;
      r_rise   <= w_rise;
      r_cnt    <= w_cnt;
    end
  end

  // Phase sequencing; the boundary decides run-on or halt.
  always_comb begin
    w_nxt  = r_state;
    w_pcnt = r_pcnt + CW'(1);
    w_bnd  = 1'b0;
    unique case (r_state)
      HALT: begin
        w_pcnt = '0;
        if (bus.run || bus.step) w_nxt = PH1;
      end
      PH1: begin
        if (r_pcnt == P1L) begin
          w_pcnt = '0;
          if (GAP_W > 0) w_nxt = GAP12;
          else           w_nxt = PH2;
        end
      end
      GAP12: begin
        if (r_pcnt == GL) begin
          w_pcnt = '0;
          w_nxt  = PH2;
        end
      end
      PH2: begin
        if (r_pcnt == P2L) begin
          w_pcnt = '0;
          if (GAP_W > 0) begin
            w_nxt = GAP21;
          end else begin
            w_bnd = 1'b1;
            w_nxt = bus.run ? PH1 : HALT;
          end
        end
      end
      GAP21: begin
        if (r_pcnt == GL) begin
          w_pcnt = '0;
          w_bnd  = 1'b1;
          w_nxt  = bus.run ? PH1 : HALT;
        end
      end
      default: begin
        w_pcnt = '0;
        w_nxt  = HALT;
      end
    endcase
  end

  // Outputs decoded from the state being entered.
  always_comb begin
    w_halted = (w_nxt == HALT);
    w_phi1   = (w_nxt == PH1);
    w_rise   = (w_nxt == PH1) && (r_state != PH1);
    w_phi2   = (w_nxt == PH2);
    w_ld     = (w_nxt == PH2) && (w_pcnt == P2L);
    w_cnt    = w_bnd ? r_cnt + CNT_W'(1) : r_cnt;
  end

  assign bus.halted    = r_halted;
  assign bus.phi1      = r_phi1;
  assign bus.phi2      = r_phi2;
  assign bus.ld        = r_ld;
  assign bus.phi1_rise = r_rise;
  assign bus.cyc_cnt   = r_cnt;

endmodule
